// File: rtl/output_crossfade_mixer.sv
// ----------------------------------------------------------------------------
// output_crossfade_mixer
//
// Final audio stage ahead of the speaker PDM. Picks one of NUM_SRC signed
// sample streams and applies a linear fade-out / fade-in (2**FADE_LOG2 sample
// triggers per ramp) whenever the selection or mute changes, so switching is
// click-free. The result is biased by DC_OFFSET, saturated to WIDTH bits and
// presented as level_out, three cycles after each sample_trigger.
//
// Optional feature macro: OUTPUT_METER_EN adds a peak meter of |y - DC_OFFSET|.
//
// Ports
//   audio_clk        in   clock
//   rst_in           in   asynchronous, active-low reset
//   sample_trigger   in   1-cycle strobe per audio sample
//   src_data         in   packed streams, src k at [k*WIDTH +: WIDTH]
//   src_sel          in   requested source; >= NUM_SRC means mute
//   mute_in          in   1 = fade to silence (bias only)
//   level_out        out  biased, saturated sample
//   level_valid_out  out  1-cycle pulse when level_out updates
//   fade_busy_out    out  1 while the gain is ramping or swapping
//   peak_clear_in    in   (OUTPUT_METER_EN) zero the peak meter
//   peak_abs_out     out  (OUTPUT_METER_EN) peak |level - DC_OFFSET|
// ----------------------------------------------------------------------------
module output_crossfade_mixer #(
    parameter int NUM_SRC   = 8,
    parameter int WIDTH     = 16,
    parameter int FADE_LOG2 = 8,
    parameter int DC_OFFSET = 2000
) (
    input  logic                       audio_clk,
    input  logic                       rst_in,
    input  logic                       sample_trigger,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    input  logic [$clog2(NUM_SRC)-1:0] src_sel,
    input  logic                       mute_in,
`ifdef OUTPUT_METER_EN
    input  logic                       peak_clear_in,
    output logic [WIDTH-2:0]           peak_abs_out,
`endif
    output logic signed [WIDTH-1:0]    level_out,
    output logic                       level_valid_out,
    output logic                       fade_busy_out
);
    localparam int SW     = $clog2(NUM_SRC);
    localparam int GW     = FADE_LOG2 + 1;
    localparam int PW     = WIDTH + FADE_LOG2 + 2;
    localparam int QW     = WIDTH + 2;
    localparam int YW     = (WIDTH + 3 > 33) ? WIDTH + 3 : 33;
    localparam int STAGES = 3;

    localparam logic [GW-1:0]        G_MAX  = {1'b1, {FADE_LOG2{1'b0}}};
    localparam logic [GW-1:0]        G_ONE  = GW'(1);
    localparam logic [SW:0]          K_NONE = {1'b1, {SW{1'b0}}};
    localparam logic signed [YW-1:0] Y_DC   = YW'(DC_OFFSET);
    localparam logic signed [YW-1:0] Y_MAX  = YW'((2**(WIDTH-1)) - 1);
    localparam logic signed [YW-1:0] Y_MIN  = ~Y_MAX;

    function automatic logic signed [WIDTH-1:0] f_sat(input logic signed [YW-1:0] v);
        if (v > Y_MAX)      f_sat = Y_MAX[WIDTH-1:0];
        else if (v < Y_MIN) f_sat = Y_MIN[WIDTH-1:0];
        else                f_sat = v[WIDTH-1:0];
    endfunction

    localparam logic signed [WIDTH-1:0] LVL_RST = f_sat(Y_DC);

    // ---------------- selection / gain FSM ----------------
    typedef enum logic [2:0] {ST_STEADY, ST_FADE_OUT, ST_SWAP, ST_MUTED, ST_FADE_IN} state_t;

    state_t        r_state, w_state_nx, w_up_state, w_dn_state;
    logic [GW-1:0] r_gain, w_gain_nx, w_gain_up, w_gain_dn;
    // Source key: MSB set = NONE (silence), low bits = stream index.
    logic [SW:0]   r_active, w_active_nx, w_target;
    logic          w_sel_oob;

    generate
        if (NUM_SRC == (1 << SW)) begin : g_sel_full
            assign w_sel_oob = 1'b0;
        end else begin : g_sel_part
            assign w_sel_oob = (int'(src_sel) >= NUM_SRC);
        end
    endgenerate

    always_comb begin
        w_target   = (mute_in || w_sel_oob) ? K_NONE : {1'b0, src_sel};
        w_gain_up  = r_gain + G_ONE;
        w_up_state = (w_gain_up == G_MAX) ? ST_STEADY : ST_FADE_IN;
        // Startup can request a fade-out at gain 0; go straight to the swap.
        w_gain_dn  = (r_gain <= G_ONE) ? '0 : r_gain - G_ONE;
        w_dn_state = (r_gain <= G_ONE) ? ST_SWAP : ST_FADE_OUT;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_gain_nx   = r_gain;
        w_active_nx = r_active;
        if (sample_trigger) begin
            case (r_state)
                ST_STEADY: begin
                    if (w_target != r_active) begin
                        w_state_nx = w_dn_state;
                        w_gain_nx  = w_gain_dn;
                    end
                end
                ST_FADE_OUT, ST_FADE_IN: begin
                    // Retargeting reverses the ramp from the current gain.
                    if (w_target != r_active) begin
                        w_state_nx = w_dn_state;
                        w_gain_nx  = w_gain_dn;
                    end else begin
                        w_state_nx = w_up_state;
                        w_gain_nx  = w_gain_up;
                    end
                end
                ST_SWAP: begin
                    w_active_nx = w_target;
                    if (w_target[SW]) begin
                        w_state_nx = ST_MUTED;
                    end else begin
                        w_state_nx = w_up_state;
                        w_gain_nx  = w_gain_up;
                    end
                end
                ST_MUTED: begin
                    if (!w_target[SW]) begin
                        w_active_nx = w_target;
                        w_state_nx  = w_up_state;
                        w_gain_nx   = w_gain_up;
                    end
                end
                default: begin
                    w_state_nx = ST_FADE_IN;
                    w_gain_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= ST_FADE_IN;
            r_gain   <= '0;
            r_active <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_gain   <= w_gain_nx;
            r_active <= w_active_nx;
        end
    end

    always_comb begin
        fade_busy_out = (r_state == ST_FADE_OUT) || (r_state == ST_SWAP) ||
                        (r_state == ST_FADE_IN);
    end

    // ---------------- datapath: select / scale / bias+clamp ----------------
    logic [NUM_SRC-1:0][WIDTH-1:0] w_src;
    logic [STAGES-1:0]             r_vld_pipe;
    logic signed [WIDTH-1:0]       r_s1_x;
    logic [GW-1:0]                 r_s1_g;
    logic signed [QW-1:0]          r_s2_p;
    logic signed [PW-1:0]          w_prod;
    logic signed [YW-1:0]          w_sum;

    assign w_src = src_data;

    always_comb begin
        w_prod = PW'(r_s1_x) * PW'($signed({1'b0, r_s1_g}));
        w_sum  = YW'(r_s2_p) + Y_DC;
    end

    // S1 captures the pre-update gain and source on the trigger edge itself.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_vld_pipe <= '0;
            r_s1_x     <= '0;
            r_s1_g     <= '0;
            r_s2_p     <= '0;
            level_out  <= LVL_RST;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-2:0], sample_trigger};
            if (sample_trigger) begin
                r_s1_x <= w_src[r_active[SW-1:0]];
                r_s1_g <= r_gain;
            end
            if (r_vld_pipe[0]) r_s2_p    <= QW'(w_prod >>> FADE_LOG2);
            if (r_vld_pipe[1]) level_out <= f_sat(w_sum);
        end
    end

    assign level_valid_out = r_vld_pipe[STAGES-1];

`ifdef OUTPUT_METER_EN
    logic signed [YW-1:0] w_dev;
    logic [WIDTH-2:0]     w_mag;

    always_comb begin
        w_dev = YW'(level_out) - Y_DC;
        if (w_dev < 0) w_dev = -w_dev;
        w_mag = (w_dev > Y_MAX) ? '1 : w_dev[WIDTH-2:0];
    end

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in)                             peak_abs_out <= '0;
        else if (peak_clear_in)                  peak_abs_out <= '0;
        else if (level_valid_out && w_mag > peak_abs_out) peak_abs_out <= w_mag;
    end
`endif

endmodule

// File: tb/tb_output_crossfade_mixer.sv
module tb_output_crossfade_mixer;
    localparam int NS    = 5;
    localparam int W     = 16;
    localparam int FL    = 2;
    localparam int UNITY = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            trig;
    logic            mute;
    logic [NS*W-1:0] data;
    logic [2:0]      sel;
    logic signed [W-1:0] lvl_p, lvl_n;
    logic            vld_p, vld_n, busy_p, busy_n;
`ifdef OUTPUT_METER_EN
    logic            clr;
    logic [W-2:0]    peak_p, peak_n;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    output_crossfade_mixer #(.NUM_SRC(NS), .WIDTH(W), .FADE_LOG2(FL), .DC_OFFSET(2000)) u_pos (
        .audio_clk(clk), .rst_in(rst_n), .sample_trigger(trig), .src_data(data),
        .src_sel(sel), .mute_in(mute),
`ifdef OUTPUT_METER_EN
        .peak_clear_in(clr), .peak_abs_out(peak_p),
`endif
        .level_out(lvl_p), .level_valid_out(vld_p), .fade_busy_out(busy_p));

    output_crossfade_mixer #(.NUM_SRC(NS), .WIDTH(W), .FADE_LOG2(FL), .DC_OFFSET(-2000)) u_neg (
        .audio_clk(clk), .rst_in(rst_n), .sample_trigger(trig), .src_data(data),
        .src_sel(sel), .mute_in(mute),
`ifdef OUTPUT_METER_EN
        .peak_clear_in(clr), .peak_abs_out(peak_n),
`endif
        .level_out(lvl_n), .level_valid_out(vld_n), .fade_busy_out(busy_n));

    typedef struct { int yp; int yn; int cyc; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference: gain in 0..UNITY, active source (-1 = silence),
    // a pending swap at gain 0, and a parked-silent flag.
    int m_gain, m_active;
    bit m_swap, m_muted;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int level(input int x, input int g, input int dc);
        int prod, q, y;
        prod = x * g;
        q = prod / UNITY;
        if (prod < 0 && (prod % UNITY) != 0) q = q - 1;   // floor division
        y = q + dc;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    function automatic int src_at(input int k);
        logic signed [W-1:0] v;
        v = data[k*W +: W];
        return int'(v);
    endfunction

    function automatic int mag(input int y, input int dc);
        int d;
        d = (y > dc) ? y - dc : dc - y;
        return (d > 32767) ? 32767 : d;
    endfunction

    function automatic bit m_busy();
        return !m_muted && (m_swap || m_gain < UNITY);
    endfunction

    task automatic model_reset();
        m_gain = 0; m_active = 0; m_swap = 0; m_muted = 0;
    endtask

    task automatic model_trigger();
        int tgt, x;
        exp_t e;
        tgt = (mute || int'(sel) >= NS) ? -1 : int'(sel);
        x = (m_active < 0) ? 0 : src_at(m_active);
        e.yp = level(x, m_gain, 2000);
        e.yn = level(x, m_gain, -2000);
        e.cyc = cyc + 3;
        sb.push_back(e);
        if (m_muted) begin
            if (tgt >= 0) begin m_active = tgt; m_gain = 1; m_muted = 0; end
        end else if (m_swap) begin
            m_swap = 0; m_active = tgt;
            if (tgt < 0) m_muted = 1; else m_gain = 1;
        end else if (tgt != m_active) begin
            if (m_gain > 0) m_gain--;
            if (m_gain == 0) m_swap = 1;
        end else if (m_gain < UNITY) begin
            m_gain++;
        end
    endtask

    task automatic set_src(input int k, input int v);
        data[k*W +: W] = W'(v);
    endtask

    task automatic tick(input bit t);
        trig = t;
`ifdef OUTPUT_METER_EN
        clr = ($urandom_range(0, 31) == 0);
`endif
        if (t) model_trigger();
        @(posedge clk); #1;
        trig = 1'b0;
        if (t) begin
            chk("busy_pos", int'(busy_p), int'(m_busy()));
            chk("busy_neg", int'(busy_n), int'(m_busy()));
        end
    endtask

    task automatic trig_n(input int n, input int gap);
        repeat (n) begin
            tick(1'b1);
            repeat (gap) tick(1'b0);
        end
    endtask

    task automatic churn();
        for (int k = 0; k < NS; k++) set_src(k, int'($urandom_range(0, 65535)) - 32768);
        if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
        mute = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        int last_p, last_n, mp, mn;
        exp_t e;
        rst_n = 1'b0; trig = 1'b0; mute = 1'b0; sel = '0; data = '0;
`ifdef OUTPUT_METER_EN
        clr = 1'b0;
`endif
        last_p = 2000; last_n = -2000; mp = 0; mn = 0;
        model_reset();

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        last_p = 2000; last_n = -2000; mp = 0; mn = 0;
                    end else begin
`ifdef OUTPUT_METER_EN
                        chk("peak_pos", int'(peak_p), mp);
                        chk("peak_neg", int'(peak_n), mn);
`endif
                        if (sb.size() > 0 && sb[0].cyc < cyc) begin
                            e = sb.pop_front();
                            chk("missed_valid_cycle", cyc, e.cyc);
                        end
                        if (vld_p) begin
                            if (sb.size() == 0) begin
                                chk("spurious_valid", int'(vld_p), 0);
                            end else begin
                                e = sb.pop_front();
                                chk("valid_cycle", cyc, e.cyc);
                                chk("level_pos", int'(lvl_p), e.yp);
                                chk("level_neg", int'(lvl_n), e.yn);
                                chk("valid_neg", int'(vld_n), 1);
                                last_p = e.yp; last_n = e.yn;
                            end
                        end else begin
                            chk("valid_neg_idle", int'(vld_n), 0);
                            chk("hold_pos", int'(lvl_p), last_p);
                            chk("hold_neg", int'(lvl_n), last_n);
                        end
`ifdef OUTPUT_METER_EN
                        if (clr) begin
                            mp = 0; mn = 0;
                        end else if (vld_p) begin
                            if (mag(last_p, 2000) > mp)  mp = mag(last_p, 2000);
                            if (mag(last_n, -2000) > mn) mn = mag(last_n, -2000);
                        end
`endif
                    end
                end
            end
            begin : watchdog
                #2000000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level_pos", int'(lvl_p), 2000);
        chk("rst_level_neg", int'(lvl_n), -2000);
        chk("rst_valid", int'(vld_p), 0);
        chk("rst_busy", int'(busy_p), 1);
        rst_n = 1'b1;

        // Startup ramp-in on src0=1000
        set_src(0, 1000);
        trig_n(6, 3);
        // Crossfade to src1=-4000
        set_src(1, -4000); sel = 3'd1;
        trig_n(9, 3);
        // Back to src0, then reverse mid fade-out
        sel = 3'd0; trig_n(9, 3);
        sel = 3'd1; trig_n(2, 3);
        sel = 3'd0; trig_n(4, 3);
        // Saturation both ways
        set_src(0, 32767);  trig_n(2, 3);
        set_src(0, -32768); trig_n(2, 3);
        // Out-of-range select behaves as mute
        sel = 3'd7; trig_n(7, 2);
        sel = 3'd2; set_src(2, 12345); trig_n(6, 2);
        // Mute, park, unmute, then reset with a sample in flight
        mute = 1'b1; trig_n(8, 1);
        mute = 1'b0; trig_n(2, 1);
        tick(1'b1);
        tick(1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        sb.delete();
        #1;
        chk("midrst_level_pos", int'(lvl_p), 2000);
        chk("midrst_level_neg", int'(lvl_n), -2000);
        chk("midrst_valid", int'(vld_p), 0);
        chk("midrst_busy", int'(busy_p), 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) tick(1'b0);

        // Randomized: back-to-back and spaced triggers, inputs churning between
        for (int i = 0; i < 400; i++) begin
            churn();
            tick(1'b1);
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 1) == 1) churn();
                tick(1'b0);
            end
        end

        repeat (8) tick(1'b0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
